// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch-stage bus: imem read port, redirect input, IF/ID handshake
interface instruction_fetch_unit_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        if_fault;

    modport master (
        output imem_pc, if_valid, if_pc, if_pc_plus4, if_instr, if_fault,
        input  imem_instr, redirect_valid, redirect_target, id_ready
    );

    modport slave (
        input  imem_pc, if_valid, if_pc, if_pc_plus4, if_instr, if_fault,
        output imem_instr, redirect_valid, redirect_target, id_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RV32I fetch stage: PC, IF/ID register, redirect flush, fetch faults
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_SIZE  = 1024,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst_n,
    instruction_fetch_unit_if.master     bus
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;

    logic        advance;
    logic        fault_now;
    logic [31:0] pc_plus4;

    assign pc_plus4  = pc_q + 32'd4;
    assign fault_now = (pc_q[1:0] != 2'b00) || (pc_q >= MEM_LIMIT);
    assign advance   = (!valid_q || bus.id_ready) && (state_q == ST_RUN);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        if_pc_d  = if_pc_q;
        if_pc4_d = if_pc4_q;
        instr_d  = instr_q;
        fault_d  = fault_q;

        if (bus.redirect_valid) begin
            // Redirect flushes the IF/ID entry even if decode is stalled.
            pc_d    = bus.redirect_target;
            valid_d = 1'b0;
            fault_d = 1'b0;
            state_d = ST_RUN;
        end else if (advance) begin
            if_pc_d  = pc_q;
            if_pc4_d = pc_plus4;
            valid_d  = 1'b1;
            if (fault_now) begin
                instr_d = NOP_INSTR;
                fault_d = 1'b1;
                state_d = ST_FAULT;
            end else begin
                instr_d = bus.imem_instr;
                fault_d = 1'b0;
                pc_d    = pc_plus4;
            end
        end else if (state_q == ST_FAULT && valid_q && bus.id_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            if_pc_q  <= 32'h0;
            if_pc4_q <= 32'h0;
            instr_q  <= NOP_INSTR;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            if_pc_q  <= if_pc_d;
            if_pc4_q <= if_pc4_d;
            instr_q  <= instr_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.imem_pc     = pc_q;
    assign bus.if_valid    = valid_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_pc_plus4 = if_pc4_q;
    assign bus.if_instr    = instr_q;
    assign bus.if_fault    = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .MEM_SIZE  (1024),
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hA000_0000 | (addr >> 2);
    endfunction

    assign bus.imem_instr = mem_word(bus.imem_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_imem;
        logic        chk;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    vec_t        exp_q[$];
    logic [31:0] stream_q[$];

    task automatic add(input string name, input logic r, input logic rv, input logic [31:0] tgt,
                       input logic rdy, input logic ev, input logic ef, input logic [31:0] eimem,
                       input logic chk, input logic [31:0] epc, input logic [31:0] epc4,
                       input logic [31:0] einstr);
        vec_t v;
        v.rst_n = r; v.rv = rv; v.tgt = tgt; v.rdy = rdy;
        v.e_valid = ev; v.e_fault = ef; v.e_imem = eimem;
        v.chk = chk; v.e_pc = epc; v.e_pc4 = epc4; v.e_instr = einstr; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        e;
        int          accepted;
        logic [31:0] spc;
        logic [31:0] sinstr;
        checks = 0;
        errors = 0;

        //   name        rst rv tgt           rdy  val flt imem_pc        chk if_pc          pc+4           instr
        add("reset",       0, 0, 32'h0,        1,  0,  0,  32'h0,         1,  32'h0,         32'h0,         NOP);
        add("fetch_A",     1, 0, 32'h0,        1,  1,  0,  32'h4,         1,  32'h0,         32'h4,         mem_word(32'h0));
        add("fetch_B",     1, 0, 32'h0,        1,  1,  0,  32'h8,         1,  32'h4,         32'h8,         mem_word(32'h4));
        add("hold_B_1",    1, 0, 32'h0,        0,  1,  0,  32'h8,         1,  32'h4,         32'h8,         mem_word(32'h4));
        add("hold_B_2",    1, 0, 32'h0,        0,  1,  0,  32'h8,         1,  32'h4,         32'h8,         mem_word(32'h4));
        add("hold_B_3",    1, 0, 32'h0,        0,  1,  0,  32'h8,         1,  32'h4,         32'h8,         mem_word(32'h4));
        add("fetch_C",     1, 0, 32'h0,        1,  1,  0,  32'hC,         1,  32'h8,         32'hC,         mem_word(32'h8));
        add("fetch_D",     1, 0, 32'h0,        1,  1,  0,  32'h10,        1,  32'hC,         32'h10,        mem_word(32'hC));
        add("redir_stall", 1, 1, 32'h40,       0,  0,  0,  32'h40,        0,  32'h0,         32'h0,         32'h0);
        add("fetch_40",    1, 0, 32'h0,        1,  1,  0,  32'h44,        1,  32'h40,        32'h44,        mem_word(32'h40));
        add("redir_42",    1, 1, 32'h42,       1,  0,  0,  32'h42,        0,  32'h0,         32'h0,         32'h0);
        add("misalign",    1, 0, 32'h0,        0,  1,  1,  32'h42,        1,  32'h42,        32'h46,        NOP);
        add("misal_hold",  1, 0, 32'h0,        0,  1,  1,  32'h42,        1,  32'h42,        32'h46,        NOP);
        add("misal_acc",   1, 0, 32'h0,        1,  0,  1,  32'h42,        0,  32'h0,         32'h0,         32'h0);
        add("fault_idle",  1, 0, 32'h0,        1,  0,  1,  32'h42,        0,  32'h0,         32'h0,         32'h0);
        add("redir_0",     1, 1, 32'h0,        1,  0,  0,  32'h0,         0,  32'h0,         32'h0,         32'h0);
        add("resume_0",    1, 0, 32'h0,        1,  1,  0,  32'h4,         1,  32'h0,         32'h4,         mem_word(32'h0));
        add("redir_3f8",   1, 1, 32'h3F8,      1,  0,  0,  32'h3F8,       0,  32'h0,         32'h0,         32'h0);
        add("fetch_3f8",   1, 0, 32'h0,        1,  1,  0,  32'h3FC,       1,  32'h3F8,       32'h3FC,       mem_word(32'h3F8));
        add("fetch_3fc",   1, 0, 32'h0,        1,  1,  0,  32'h400,       1,  32'h3FC,       32'h400,       mem_word(32'h3FC));
        add("range_flt",   1, 0, 32'h0,        1,  1,  1,  32'h400,       1,  32'h400,       32'h404,       NOP);
        add("range_acc",   1, 0, 32'h0,        1,  0,  1,  32'h400,       0,  32'h0,         32'h0,         32'h0);
        add("range_idle",  1, 0, 32'h0,        1,  0,  1,  32'h400,       0,  32'h0,         32'h0,         32'h0);
        add("redir_top",   1, 1, 32'hFFFF_FFFC,1,  0,  0,  32'hFFFF_FFFC, 0,  32'h0,         32'h0,         32'h0);
        add("wrap_flt",    1, 0, 32'h0,        0,  1,  1,  32'hFFFF_FFFC, 1,  32'hFFFF_FFFC, 32'h0,         NOP);
        add("redir_flush", 1, 1, 32'h1C,       0,  0,  0,  32'h1C,        0,  32'h0,         32'h0,         32'h0);
        add("fetch_1c",    1, 0, 32'h0,        1,  1,  0,  32'h20,        1,  32'h1C,        32'h20,        mem_word(32'h1C));
        add("mid_reset",   0, 0, 32'h0,        1,  0,  0,  32'h0,         1,  32'h0,         32'h0,         NOP);
        add("post_reset",  1, 0, 32'h0,        1,  1,  0,  32'h4,         1,  32'h0,         32'h4,         mem_word(32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n               = vecs[i].rst_n;
            bus.redirect_valid  = vecs[i].rv;
            bus.redirect_target = vecs[i].tgt;
            bus.id_ready        = vecs[i].rdy;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            cmp({e.name, ".if_valid"}, 32'(bus.if_valid), 32'(e.e_valid));
            cmp({e.name, ".if_fault"}, 32'(bus.if_fault), 32'(e.e_fault));
            cmp({e.name, ".imem_pc"},  bus.imem_pc, e.e_imem);
            if (e.chk) begin
                cmp({e.name, ".if_pc"},       bus.if_pc, e.e_pc);
                cmp({e.name, ".if_pc_plus4"}, bus.if_pc_plus4, e.e_pc4);
                cmp({e.name, ".if_instr"},    bus.if_instr, e.e_instr);
            end
        end

        // Random decode back-pressure: every accepted entry must be the next sequential word.
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.id_ready        = 1'b1;
        rst_n               = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 64; k++) stream_q.push_back(32'(k * 4));
        accepted = 0;
        for (int c = 0; c < 80; c++) begin
            bus.id_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.if_valid && bus.id_ready) begin
                spc    = stream_q.pop_front();
                sinstr = mem_word(spc);
                cmp("stream.if_pc",    bus.if_pc, spc);
                cmp("stream.if_instr", bus.if_instr, sinstr);
                cmp("stream.if_fault", 32'(bus.if_fault), 32'h0);
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        cmp("stream.min_accepts", 32'(accepted >= 10), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
